// File: rtl/bus_memory_responder.sv
// Instruction-fetch bus target: word-addressed memory with a fixed-latency response
// pipeline and a cap on accepted-but-unacknowledged requests.
module bus_memory_responder #(
    parameter int unsigned AddrBits       = 12,
    parameter int unsigned Latency        = 3,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        BusCycle,
    input  logic        BusStrobe,
    input  logic        BusReadWrite,
    input  logic [3:0]  BusSelect,
    input  logic [31:0] MemoryAddress,
    input  logic [31:0] MemoryDataIn,
    output logic [31:0] MemoryDataOut,
    output logic        BusAcknowledge,
    output logic        BusStall
);

    localparam int unsigned Depth   = 2 ** AddrBits;
    localparam int unsigned CntBits = $clog2(MaxOutstanding + 1);

    logic [31:0]          mem [Depth];
    logic [AddrBits-1:0]  word_addr;
    logic                 unused_addr_bits;
    logic                 accept;
    logic                 ack_issue;
    logic [31:0]          write_word;
    logic [31:0]          entry_data;

    logic [CntBits-1:0]   outstanding_q, outstanding_d;
    logic [Latency-1:0]   valid_q;
    logic [31:0]          data_q [Latency];

    assign word_addr        = MemoryAddress[AddrBits-1:0];
    assign unused_addr_bits = ^MemoryAddress[31:AddrBits];

    assign BusStall  = (outstanding_q == CntBits'(MaxOutstanding));
    // A request seen during the reset cycle is dropped, not queued.
    assign accept    = BusCycle & BusStrobe & ~BusStall & ~Reset;
    assign ack_issue = valid_q[Latency-1] & BusCycle;

    assign BusAcknowledge = ack_issue;
    assign MemoryDataOut  = ack_issue ? data_q[Latency-1] : 32'h0;

    always_comb begin
        write_word = mem[word_addr];
        for (int i = 0; i < 4; i++) begin
            if (BusSelect[i]) begin
                write_word[8*i +: 8] = MemoryDataIn[8*i +: 8];
            end
        end
    end

    // Writes travel the pipeline as data-less entries so their acks read back as zero.
    assign entry_data = BusReadWrite ? 32'h0 : mem[word_addr];

    // Memory has no reset so contents survive Reset and aborts.
    always_ff @(posedge Clock) begin
        if (accept && BusReadWrite) begin
            mem[word_addr] <= write_word;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || !BusCycle) begin
            valid_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                data_q[i] <= 32'h0;
            end
        end else begin
            valid_q[0] <= accept;
            data_q[0]  <= entry_data;
            for (int i = 1; i < Latency; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (!BusCycle) begin
            outstanding_d = '0;
        end else if (accept && !ack_issue) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && ack_issue) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Randomised and directed bench for bus_memory_responder against a queue-based
// model of the memory and the in-order, fixed-latency response stream.
module tb_bus_memory_responder;

    localparam int unsigned AB   = 12;
    localparam int unsigned LAT  = 3;
    localparam int unsigned MAXO = 2;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        BusCycle;
    logic        BusStrobe;
    logic        BusReadWrite;
    logic [3:0]  BusSelect;
    logic [31:0] MemoryAddress;
    logic [31:0] MemoryDataIn;
    logic [31:0] MemoryDataOut;
    logic        BusAcknowledge;
    logic        BusStall;

    bus_memory_responder #(
        .AddrBits      (AB),
        .Latency       (LAT),
        .MaxOutstanding(MAXO)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .BusCycle      (BusCycle),
        .BusStrobe     (BusStrobe),
        .BusReadWrite  (BusReadWrite),
        .BusSelect     (BusSelect),
        .MemoryAddress (MemoryAddress),
        .MemoryDataIn  (MemoryDataIn),
        .MemoryDataOut (MemoryDataOut),
        .BusAcknowledge(BusAcknowledge),
        .BusStall      (BusStall)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          due;
        bit          wr;
        bit          known;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mdl_mem [4096];
    bit          mdl_known [4096];

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          acks_seen = 0;
    int          last_ack_cyc = -1;
    int          peak = 0;
    bit          last_accept;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    // to what the rising edge should do.
    task automatic step(input bit rst, input bit cy, input bit stb, input bit rw,
                        input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] din);
        bit          exp_stall;
        bit          exp_ack;
        int          idx;
        logic [31:0] w;
        @(negedge Clock);
        Reset = rst; BusCycle = cy; BusStrobe = stb; BusReadWrite = rw;
        BusSelect = sel; MemoryAddress = addr; MemoryDataIn = din;
        #1;
        exp_stall = (exp_q.size() == MAXO);
        exp_ack   = cy && (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("stall", 32'(BusStall), 32'(exp_stall));
        check("ack", 32'(BusAcknowledge), 32'(exp_ack));
        if (exp_ack) begin
            if (exp_q[0].known) check("ack_data", MemoryDataOut, exp_q[0].data);
            acks_seen++;
            last_ack_cyc = cyc;
            if (!exp_q[0].wr) last_rdata = MemoryDataOut;
        end else begin
            check("idle_data", MemoryDataOut, 32'h0);
        end
        last_accept = 1'b0;
        if (rst || !cy) begin
            exp_q.delete();
        end else begin
            if (exp_ack) void'(exp_q.pop_front());
            if (stb && !exp_stall) begin
                idx = int'(addr % 4096);
                if (rw) begin
                    w = mdl_mem[idx];
                    for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = din[8*b +: 8];
                    mdl_mem[idx]   = w;
                    mdl_known[idx] = mdl_known[idx] || (sel == 4'hF);
                    exp_q.push_back(resp_t'{due: cyc + LAT, wr: 1'b1, known: 1'b1, data: 32'h0});
                end else begin
                    exp_q.push_back(resp_t'{due: cyc + LAT, wr: 1'b0, known: mdl_known[idx],
                                            data: mdl_mem[idx]});
                end
                last_accept = 1'b1;
            end
        end
        if (exp_q.size() > peak) peak = exp_q.size();
        cyc++;
    endtask

    task automatic issue(input bit rw, input logic [31:0] addr, input logic [31:0] din,
                         input logic [3:0] sel);
        int tries = 0;
        do begin
            step(1'b0, 1'b1, 1'b1, rw, sel, addr, din);
            tries++;
        end while (!last_accept && tries < 16);
        if (!last_accept) check("accept_timeout", 32'(tries), 32'(0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    int base_acks;
    int cyc0;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mdl_mem[i] = 32'h0;
            mdl_known[i] = 1'b0;
        end
        // First reset cycle unchecked: state before any reset is undefined.
        Reset = 1'b1; BusCycle = 1'b0; BusStrobe = 1'b0; BusReadWrite = 1'b0;
        BusSelect = 4'h0; MemoryAddress = 32'h0; MemoryDataIn = 32'h0;
        @(posedge Clock);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);   // request in reset cycle dropped
        idle(LAT + 1);
        check("reset_no_ack", 32'(acks_seen), 32'(0));

        // Preload through the bus.
        for (int i = 0; i < 64; i++) issue(1'b1, 32'(i), $urandom, 4'hF);
        issue(1'b1, 32'h010, 32'hDEADBEEF, 4'hF);
        issue(1'b1, 32'h020, 32'h11223344, 4'hF);
        issue(1'b1, 32'h005, 32'h5A5A0005, 4'hF);
        for (int i = 0; i < 8; i++) issue(1'b1, 32'h100 + 32'(i), 32'hC0DE0000 + 32'(i), 4'hF);
        idle(LAT + 1);

        // Single read into an idle pipeline.
        cyc0 = cyc;
        issue(1'b0, 32'h010, 32'h0, 4'h0);
        idle(LAT + 1);
        check("single_latency", 32'(last_ack_cyc - cyc0), 32'(LAT));
        check("single_data", last_rdata, 32'hDEADBEEF);

        // Eight-beat burst.
        base_acks = acks_seen;
        peak = 0;
        for (int i = 0; i < 8; i++) issue(1'b0, 32'h100 + 32'(i), 32'h0, 4'h0);
        idle(LAT + 1);
        check("burst_acks", 32'(acks_seen - base_acks), 32'(8));
        check("burst_peak", 32'(peak), 32'(MAXO));
        check("burst_last", last_rdata, 32'hC0DE0007);

        // Byte-select write then read.
        issue(1'b1, 32'h020, 32'hAABBCCDD, 4'b0101);
        issue(1'b0, 32'h020, 32'h0, 4'h0);
        idle(LAT + 1);
        check("bytesel", last_rdata, 32'h11BB33DD);

        // Abort with two reads in flight.
        base_acks = acks_seen;
        issue(1'b0, 32'h010, 32'h0, 4'h0);
        issue(1'b0, 32'h011, 32'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h012, 32'h0);
        idle(LAT + 2);
        check("abort_no_ack", 32'(acks_seen - base_acks), 32'(0));
        cyc0 = cyc;
        issue(1'b0, 32'h010, 32'h0, 4'h0);
        idle(LAT + 1);
        check("abort_fresh_lat", 32'(last_ack_cyc - cyc0), 32'(LAT));

        // Reset mid-burst.
        base_acks = acks_seen;
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        issue(1'b0, 32'h101, 32'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 32'h102, 32'h0);
        idle(LAT + 2);
        check("reset_no_ack_mid", 32'(acks_seen - base_acks), 32'(0));
        issue(1'b0, 32'h020, 32'h0, 4'h0);
        idle(LAT + 1);
        check("reset_retained", last_rdata, 32'h11BB33DD);

        // Upper address bits ignored.
        issue(1'b0, 32'hFFFF_F005, 32'h0, 4'h0);
        idle(LAT + 1);
        check("alias", last_rdata, 32'h5A5A0005);

        // Random traffic over the preloaded window.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 100) == 0, ($urandom % 25) != 0, ($urandom % 4) != 0,
                 ($urandom % 3) == 0, 4'($urandom),
                 ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)), $urandom);
        end
        idle(LAT + 1);
        check("final_drained", 32'(exp_q.size()), 32'(0));
        check("final_stall", 32'(BusStall), 32'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
